// File: rtl/moe_rx_msg_id_mgr.sv
// MOE receive-path resource manager: free message-ID pool, receive credits and RX FIFO
// occupancy, with a packed status word and one-cycle error pulses.
module moe_rx_msg_id_mgr #(
    parameter int unsigned ID_NUM     = 64,
    parameter int unsigned ID_WID     = $clog2(ID_NUM),
    parameter int unsigned RCV_ID_NUM = 32,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_init_done,
    output logic              o_id_vld,
    input  logic              i_id_rdy,
    output logic [ID_WID-1:0] o_alloc_id,
    input  logic              i_rel_vld,
    input  logic [ID_WID-1:0] i_rel_id,
    input  logic              i_rcv_take,
    input  logic              i_rcv_give,
    input  logic              i_fifo_wr,
    input  logic              i_fifo_rd,
    output logic [47:0]       o_rx_fifo_st,
    output logic [3:0]        o_err_pulse
);

    localparam logic [ID_WID:0] LP_ID_NUM     = (ID_WID+1)'(ID_NUM);
    localparam logic [15:0]     LP_RCV_ID_NUM = 16'(RCV_ID_NUM);
    localparam logic [15:0]     LP_FIFO_DEPTH = 16'(FIFO_DEPTH);

    typedef enum logic {StInit, StRun} state_e;

    state_e            r_state;
    logic              r_init_done;
    logic [ID_WID-1:0] r_free_list [ID_NUM];
    logic [ID_WID-1:0] r_rd_ptr;
    logic [ID_WID-1:0] r_wr_ptr;
    logic [ID_WID:0]   r_free_cnt;
    logic [ID_NUM-1:0] r_in_use;
    logic [15:0]       r_credit;
    logic [15:0]       r_fifo_used;
    logic [47:0]       r_rx_fifo_st;
    logic [3:0]        r_err;

    logic              w_run;
    logic              w_id_vld;
    logic [ID_WID-1:0] w_alloc_id;
    logic              w_alloc;
    logic              w_rel_ok;
    logic              w_rel_bad;
    logic              w_alloc_bad;
    logic [15:0]       w_credit_d;
    logic              w_credit_err;
    logic [15:0]       w_fifo_used_d;
    logic              w_fifo_err;

    assign w_run       = (r_state == StRun);
    assign w_id_vld    = w_run && (r_free_cnt != '0);
    assign w_alloc_id  = r_free_list[r_rd_ptr];
    assign w_alloc     = w_id_vld && i_id_rdy;
    // The in-use bit is registered, so releasing the ID being handed out this cycle is rejected.
    assign w_rel_ok    = w_run && i_rel_vld && r_in_use[i_rel_id];
    assign w_rel_bad   = i_rel_vld && !w_rel_ok;
    assign w_alloc_bad = w_run && i_id_rdy && !w_id_vld;

    always_comb begin
        w_credit_d   = r_credit;
        w_credit_err = 1'b0;
        if (i_rcv_take && !i_rcv_give) begin
            if (r_credit != '0) w_credit_d = r_credit - 16'd1;
            else                w_credit_err = 1'b1;
        end else if (i_rcv_give && !i_rcv_take) begin
            if (r_credit < LP_RCV_ID_NUM) w_credit_d = r_credit + 16'd1;
            else                          w_credit_err = 1'b1;
        end
    end

    always_comb begin
        w_fifo_used_d = r_fifo_used;
        w_fifo_err    = 1'b0;
        if (i_fifo_wr && i_fifo_rd) begin
            // Push lands before pop, so an empty FIFO ends up holding one entry.
            if (r_fifo_used == '0) w_fifo_used_d = 16'd1;
        end else if (i_fifo_wr) begin
            if (r_fifo_used < LP_FIFO_DEPTH) w_fifo_used_d = r_fifo_used + 16'd1;
            else                             w_fifo_err = 1'b1;
        end else if (i_fifo_rd) begin
            if (r_fifo_used != '0) w_fifo_used_d = r_fifo_used - 16'd1;
            else                   w_fifo_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StInit;
            r_init_done  <= 1'b0;
            r_free_list  <= '{default: '0};
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_free_cnt   <= '0;
            r_in_use     <= '0;
            r_credit     <= LP_RCV_ID_NUM;
            r_fifo_used  <= '0;
            r_rx_fifo_st <= '0;
            r_err        <= '0;
        end else begin
            r_credit     <= w_credit_d;
            r_fifo_used  <= w_fifo_used_d;
            r_err        <= {w_alloc_bad, w_fifo_err, w_credit_err, w_rel_bad};
            r_rx_fifo_st <= {r_fifo_used, {(16-ID_WID-1){1'b0}}, r_free_cnt, r_credit};
            case (r_state)
                StInit: begin
                    // Seed entry k with ID k; the write pointer doubles as the seed value.
                    if (r_free_cnt != LP_ID_NUM) begin
                        r_free_list[r_wr_ptr] <= r_wr_ptr;
                        r_wr_ptr              <= r_wr_ptr + ID_WID'(1);
                        r_free_cnt            <= r_free_cnt + (ID_WID+1)'(1);
                    end else begin
                        r_state     <= StRun;
                        r_init_done <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_alloc) begin
                        r_rd_ptr             <= r_rd_ptr + ID_WID'(1);
                        r_in_use[w_alloc_id] <= 1'b1;
                    end
                    if (w_rel_ok) begin
                        r_free_list[r_wr_ptr] <= i_rel_id;
                        r_wr_ptr              <= r_wr_ptr + ID_WID'(1);
                        r_in_use[i_rel_id]    <= 1'b0;
                    end
                    if (w_alloc && !w_rel_ok)      r_free_cnt <= r_free_cnt - (ID_WID+1)'(1);
                    else if (!w_alloc && w_rel_ok) r_free_cnt <= r_free_cnt + (ID_WID+1)'(1);
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign o_init_done  = r_init_done;
    assign o_id_vld     = w_id_vld;
    assign o_alloc_id   = w_alloc_id;
    assign o_rx_fifo_st = r_rx_fifo_st;
    assign o_err_pulse  = r_err;

endmodule

// File: tb/tb_moe_rx_msg_id_mgr.sv
// Randomized bench for moe_rx_msg_id_mgr against a queue-based model of the ID pool,
// credit counter and FIFO occupancy.
module tb_moe_rx_msg_id_mgr;

    localparam int ID_NUM     = 64;
    localparam int ID_WID     = 6;
    localparam int RCV_ID_NUM = 32;
    localparam int FIFO_DEPTH = 512;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              o_init_done;
    logic              o_id_vld;
    logic              i_id_rdy = 1'b0;
    logic [ID_WID-1:0] o_alloc_id;
    logic              i_rel_vld = 1'b0;
    logic [ID_WID-1:0] i_rel_id = '0;
    logic              i_rcv_take = 1'b0;
    logic              i_rcv_give = 1'b0;
    logic              i_fifo_wr = 1'b0;
    logic              i_fifo_rd = 1'b0;
    logic [47:0]       o_rx_fifo_st;
    logic [3:0]        o_err_pulse;

    moe_rx_msg_id_mgr #(
        .ID_NUM     (ID_NUM),
        .ID_WID     (ID_WID),
        .RCV_ID_NUM (RCV_ID_NUM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_init_done  (o_init_done),
        .o_id_vld     (o_id_vld),
        .i_id_rdy     (i_id_rdy),
        .o_alloc_id   (o_alloc_id),
        .i_rel_vld    (i_rel_vld),
        .i_rel_id     (i_rel_id),
        .i_rcv_take   (i_rcv_take),
        .i_rcv_give   (i_rcv_give),
        .i_fifo_wr    (i_fifo_wr),
        .i_fifo_rd    (i_fifo_rd),
        .o_rx_fifo_st (o_rx_fifo_st),
        .o_err_pulse  (o_err_pulse)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: free IDs in hand-out order, plus the set of IDs currently held.
    int m_free[$];
    bit m_in_use[ID_NUM];
    int m_credit;
    int m_used;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_free.delete();
        for (int k = 0; k < ID_NUM; k++) begin
            m_free.push_back(k);
            m_in_use[k] = 1'b0;
        end
        m_credit = RCV_ID_NUM;
        m_used   = 0;
    endtask

    // Entered just after rst_n deassertion; leaves at a falling edge once init_done is seen.
    task automatic wait_init();
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge i_clk);
            n++;
            #1;
            if (n == 11) check_eq("init_rel_err", 64'(o_err_pulse), 64'h1);
            if (n < 65) check_eq("init_id_vld", 64'(o_id_vld), 64'h0);
            if (o_init_done) seen = 1'b1;
            @(negedge i_clk);
            i_rel_vld = (n == 10);
            i_rel_id  = '0;
        end
        i_rel_vld = 1'b0;
        check_eq("init_cycles", 64'(n), 64'd65);
        model_reset();
    endtask

    // Called at a falling edge: drives one cycle of stimulus and checks it against the model.
    task automatic do_cyc(input bit rdy, input bit relv, input int relid, input bit take,
                          input bit give, input bit wr, input bit rd);
        bit          vld;
        bit          rel_ok;
        int          id;
        logic [3:0]  err;
        logic [47:0] st;
        i_id_rdy   = rdy;
        i_rel_vld  = relv;
        i_rel_id   = ID_WID'(relid);
        i_rcv_take = take;
        i_rcv_give = give;
        i_fifo_wr  = wr;
        i_fifo_rd  = rd;
        #1;
        vld = (m_free.size() != 0);
        check_eq("id_vld", 64'(o_id_vld), 64'(vld));
        if (vld) check_eq("alloc_id", 64'(o_alloc_id), 64'(m_free[0]));
        st  = {16'(m_used), 16'(m_free.size()), 16'(m_credit)};
        err = '0;
        if (rdy && !vld) err[3] = 1'b1;
        rel_ok = relv && m_in_use[relid];
        if (relv && !rel_ok) err[0] = 1'b1;
        if (vld && rdy) begin
            id = m_free.pop_front();
            m_in_use[id] = 1'b1;
        end
        if (rel_ok) begin
            m_free.push_back(relid);
            m_in_use[relid] = 1'b0;
        end
        if (take && !give) begin
            if (m_credit > 0) m_credit--; else err[1] = 1'b1;
        end else if (give && !take) begin
            if (m_credit < RCV_ID_NUM) m_credit++; else err[1] = 1'b1;
        end
        if (wr && rd) begin
            if (m_used == 0) m_used = 1;
        end else if (wr) begin
            if (m_used < FIFO_DEPTH) m_used++; else err[2] = 1'b1;
        end else if (rd) begin
            if (m_used > 0) m_used--; else err[2] = 1'b1;
        end
        @(posedge i_clk);
        #1;
        check_eq("err_pulse", 64'(o_err_pulse), 64'(err));
        check_eq("rx_fifo_st", 64'(o_rx_fifo_st), 64'(st));
        @(negedge i_clk);
    endtask

    task automatic idle();
        do_cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1 i_rst_n = 1'b0;
        #2;
        check_eq("rst_init_done", 64'(o_init_done), 64'h0);
        check_eq("rst_id_vld", 64'(o_id_vld), 64'h0);
        check_eq("rst_alloc_id", 64'(o_alloc_id), 64'h0);
        check_eq("rst_err", 64'(o_err_pulse), 64'h0);
        check_eq("rst_st", 64'(o_rx_fifo_st), 64'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_init();
        idle();
        check_eq("st_after_init", 64'(o_rx_fifo_st), {16'd0, 16'd0, 16'd0, 16'd64, 16'd32});

        // Drain the pool in order, then one extra ready with nothing offered.
        for (int k = 0; k < ID_NUM; k++) begin
            check_eq("seq_id", 64'(o_alloc_id), 64'(k));
            do_cyc(1, 0, 0, 0, 0, 0, 0);
        end
        do_cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("alloc_empty_err", 64'(o_err_pulse), 64'h8);
        idle();

        do_cyc(0, 1, 5, 0, 0, 0, 0);
        do_cyc(0, 1, 9, 0, 0, 0, 0);
        check_eq("reuse_first", 64'(o_alloc_id), 64'd5);
        do_cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("reuse_second", 64'(o_alloc_id), 64'd9);
        do_cyc(1, 0, 0, 0, 0, 0, 0);
        do_cyc(0, 1, 5, 0, 0, 0, 0);
        do_cyc(0, 1, 5, 0, 0, 0, 0);
        check_eq("double_free_err", 64'(o_err_pulse), 64'h1);
        idle();

        // Allocate 5 while releasing 3, then 3 comes back out; then self-release of offered ID.
        do_cyc(1, 1, 3, 0, 0, 0, 0);
        check_eq("realloc_3", 64'(o_alloc_id), 64'd3);
        do_cyc(1, 0, 0, 0, 0, 0, 0);
        do_cyc(0, 1, 7, 0, 0, 0, 0);
        do_cyc(1, 1, 7, 0, 0, 0, 0);
        idle();

        for (int k = 0; k < 33; k++) do_cyc(0, 0, 0, 1, 0, 0, 0);
        check_eq("credit_underflow", 64'(o_err_pulse), 64'h2);
        do_cyc(0, 0, 0, 1, 1, 0, 0);
        do_cyc(0, 0, 0, 0, 1, 0, 0);
        do_cyc(0, 0, 0, 1, 1, 0, 0);
        idle();

        for (int k = 0; k < FIFO_DEPTH + 1; k++) do_cyc(0, 0, 0, 0, 0, 1, 0);
        check_eq("fifo_overflow", 64'(o_err_pulse), 64'h4);
        do_cyc(0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < FIFO_DEPTH + 1; k++) do_cyc(0, 0, 0, 0, 0, 0, 1);
        do_cyc(0, 0, 0, 0, 0, 1, 1);
        idle();
        check_eq("fifo_wr_rd_at_zero", 64'(o_rx_fifo_st[47:32]), 64'd1);

        for (int k = 0; k < 3000; k++) begin
            do_cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, ID_NUM - 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of traffic.
        i_fifo_wr  = 1'b1;
        i_rcv_take = 1'b1;
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("midrst_st", 64'(o_rx_fifo_st), 64'h0);
        check_eq("midrst_init_done", 64'(o_init_done), 64'h0);
        check_eq("midrst_id_vld", 64'(o_id_vld), 64'h0);
        @(negedge i_clk);
        i_fifo_wr  = 1'b0;
        i_rcv_take = 1'b0;
        i_id_rdy   = 1'b0;
        i_rel_vld  = 1'b0;
        i_rcv_give = 1'b0;
        i_fifo_rd  = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_init();
        idle();
        for (int k = 0; k < 4; k++) do_cyc(1, 0, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/moe_rx_msg_id_mgr.md
Name: moe_rx_msg_id_mgr

Overview:
- Resource/status manager for the MOE receive path. Owns the free message-ID pool, the free receive-message-ID credit count and the RX FIFO occupancy count.
- Produces the packed 48-bit RX FIFO status word {fifo_used_cnt, free_msg_id_cnt, free_rcv_msg_id_cnt}, 16 b each, consumed by the top-level status/CSR logic.
- Sits between the RX message parser (allocates/releases IDs, pushes the FIFO) and the host-side DMA/BD stage (pops the FIFO, returns credits).

Parameters:
- ID_NUM, 64: number of message IDs in the pool; power of 2, range 2..4096.
- ID_WID, 6: $clog2(ID_NUM); message-ID width.
- RCV_ID_NUM, 32: receive-message-ID credits at reset; range 1..65535.
- FIFO_DEPTH, 512: RX FIFO depth; range 1..65535.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once the ID pool is initialised
- id_vld  out  1  a free message ID is offered
- id_rdy  in  1  consumer takes the offered ID
- alloc_id  out  ID_WID  offered message ID
- rel_vld  in  1  release one message ID (single-cycle pulse)
- rel_id  in  ID_WID  ID being released
- rcv_take  in  1  consume one receive credit
- rcv_give  in  1  return one receive credit
- fifo_wr  in  1  RX FIFO push strobe
- fifo_rd  in  1  RX FIFO pop strobe
- rx_fifo_st  out  48  registered status: [47:32] fifo_used_cnt, [31:16] free_msg_id_cnt, [15:0] free_rcv_msg_id_cnt
- err_pulse  out  4  one-cycle error flags: [0] bad release, [1] credit over/underflow, [2] FIFO over/underflow, [3] alloc while empty

Behaviour:
- Reset values:
  - init_done=0, id_vld=0, alloc_id=0, err_pulse=0, rx_fifo_st=0.
  - Internally: free count=0, in-use bitmap all 0, credit=RCV_ID_NUM, fifo_used=0, state=INIT.
- Reset asserted mid-operation clears all state asynchronously; initialisation restarts on rst_n deassertion.
- INIT state:
  - Writes free-list entry k with ID k, k=0..ID_NUM-1, one per cycle, for ID_NUM cycles.
  - The free count increments with each write.
  - Moves to RUN on the cycle after the last write; init_done goes high in RUN and stays high.
  - During INIT: id_vld=0; any rel_vld is dropped and sets err_pulse[0].
- Free list:
  - Circular buffer of ID_NUM entries with ID_WID-bit rd_ptr/wr_ptr; both pointers wrap modulo ID_NUM.
  - Free count is ID_WID+1 bits.
- Allocate:
  - id_vld = RUN && free_cnt != 0.
  - alloc_id = entry at rd_ptr, combinational read, stable while id_vld && !id_rdy.
  - The handshake fires on id_vld && id_rdy: rd_ptr++, free_cnt--, bitmap[alloc_id]=1.
  - id_rdy with id_vld=0 in RUN sets err_pulse[3] and has no other effect.
- Release:
  - Accepted when RUN && bitmap[rel_id]==1: entry at wr_ptr=rel_id, wr_ptr++, free_cnt++, bitmap[rel_id]=0.
  - Otherwise (double free, never allocated) it is dropped and sets err_pulse[0].
- Allocate and release in the same cycle:
  - Both take effect; net free_cnt unchanged.
  - Releasing the ID being allocated that same cycle is a bad release (bitmap not yet set) and is dropped.
  - A release arriving when free_cnt==0 makes the ID available next cycle.
- Credits:
  - take only: credit-- if credit>0, else hold and err_pulse[1].
  - give only: credit++ if credit<RCV_ID_NUM, else hold and err_pulse[1].
  - take and give together: no change, no error.
- FIFO count:
  - wr only: ++ if < FIFO_DEPTH, else hold and err_pulse[2].
  - rd only: -- if > 0, else hold and err_pulse[2].
  - wr and rd together: no change. The one exception is fifo_used==0, which gives +1 with no error (push lands before pop).
- Status:
  - rx_fifo_st is registered from the internal counters, zero-extended to 16 b. It is one cycle behind the counter update, so two cycles after the causing strobe edge.
- err_pulse is registered and lasts exactly one cycle per event.

Test Plan:
- Reset, idle:
  - init_done rises exactly ID_NUM+1 cycles after rst_n deassertion.
  - Next cycle rx_fifo_st = {16'd0, 16'd64, 16'd32}.
- Hold id_rdy=1 for 64 cycles: alloc_id sequence 0,1,...,63; then id_vld=0 and free_msg_id_cnt=0. Extra id_rdy gives err_pulse[3]=1 for one cycle.
- After exhaustion:
  - Release 5 then 9: next two allocations return 5 then 9.
  - Releasing 5 twice gives err_pulse[0] on the second release, and free count rises by only 1.
- Allocate and release (ID 3, previously allocated) in one cycle: free_msg_id_cnt unchanged; ID 3 is re-offered once the pointer reaches it.
- 33 rcv_take pulses from reset: credit reaches 0 after 32, and the 33rd gives err_pulse[1]. Simultaneous take+give leaves it unchanged.
- FIFO count:
  - 512 fifo_wr then one more gives fifo_used_cnt=512 plus err_pulse[2].
  - wr+rd together at 0 gives 1.
  - Asserting rst_n=0 mid-traffic clears rx_fifo_st to 0 immediately, and INIT reruns.
